// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state type for the ALU operand sequencer.
// Build option: ALU_OP_SEQUENCER_ZFLAG_EN adds a registered zero flag.
package alu_seq_pkg;

   localparam logic [2:0] OP_NEGA = 3'b000;
   localparam logic [2:0] OP_NEGB = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_XOR  = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } seqState_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x 4-bit operand registers: two async reads, one sync write.
// Host loads take priority over ALU writeback on the write port.
module alu_seq_regfile #(
   parameter int NREG = 4,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] rdAddrA,
   input  logic [AW-1:0] rdAddrB,
   output logic [3:0]    rdDataA,
   output logic [3:0]    rdDataB,
   input  logic          ldEn,
   input  logic [AW-1:0] ldAddr,
   input  logic [3:0]    ldData,
   input  logic          wbEn,
   input  logic [AW-1:0] wbAddr,
   input  logic [3:0]    wbData
);

   logic [3:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (ldEn) begin
         regs[ldAddr] <= ldData;
      end else if (wbEn) begin
         regs[wbAddr] <= wbData;
      end
   end

   assign rdDataA = regs[rdAddrA];
   assign rdDataB = regs[rdAddrB];

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds register operands to an external combinational ALU and returns its result.
// Build option: ALU_OP_SEQUENCER_ZFLAG_EN adds output rsp_zero.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int NREG = 4,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [3:0]    ld_data,
   output logic          ld_ready,
   input  logic          cmd_valid,
   input  logic [2:0]    cmd_op,
   input  logic [AW-1:0] cmd_dst,
   input  logic [AW-1:0] cmd_srca,
   input  logic [AW-1:0] cmd_srcb,
   output logic          cmd_ready,
   output logic [3:0]    alu_a,
   output logic [3:0]    alu_b,
   output logic [2:0]    alu_c,
   input  logic [3:0]    alu_s,
   output logic          rsp_valid,
   output logic [3:0]    rsp_data,
`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
   output logic          rsp_zero,
   input  logic          rsp_ready
`else
   input  logic          rsp_ready
`endif
);

   seqState_t     state;
   seqState_t     nextState;
   logic [AW-1:0] dstQ;
   logic [3:0]    rdA;
   logic [3:0]    rdB;
   logic          ldFire;
   logic          cmdFire;
   logic          wbEn;

   assign ldFire  = ld_valid && ld_ready;
   assign cmdFire = cmd_valid && cmd_ready;
   assign wbEn    = (state == CAPTURE) && !reset;

   alu_seq_regfile #(
      .NREG (NREG),
      .AW   (AW)
   ) uRegs (
      .clk     (clk),
      .reset   (reset),
      .rdAddrA (cmd_srca),
      .rdAddrB (cmd_srcb),
      .rdDataA (rdA),
      .rdDataB (rdB),
      .ldEn    (ldFire),
      .ldAddr  (ld_addr),
      .ldData  (ld_data),
      .wbEn    (wbEn),
      .wbAddr  (dstQ),
      .wbData  (alu_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      ld_ready  = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         IDLE: begin
            ld_ready  = !reset;
            cmd_ready = !reset && !ld_valid;
            if (cmd_valid && cmd_ready) begin
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            nextState = CAPTURE;
         end
         CAPTURE: begin
            nextState = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Operands are read at the command handshake, so an aliased dst sees old values.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_c    <= '0;
         dstQ     <= '0;
         rsp_data <= '0;
      end else begin
         if (cmdFire) begin
            alu_a <= rdA;
            alu_b <= rdB;
            alu_c <= cmd_op;
            dstQ  <= cmd_dst;
         end
         if (state == CAPTURE) begin
            rsp_data <= alu_s;
         end
      end
   end

`ifdef ALU_OP_SEQUENCER_ZFLAG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_zero <= 1'b0;
      end else if (state == CAPTURE) begin
         rsp_zero <= (alu_s == 4'd0);
      end
   end
`endif

endmodule
